// File: rtl/sd_cmd_arbiter_pkg.sv
// Shared SD command-path definitions: arbiter FSM state encoding,
// command owner encoding and the round-robin pick helper.
package sd_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_DMA  = 1'b1;

  // Pick the requester to serve; on a tie the one that did not go last wins.
  function automatic logic rr_pick(input logic host_req,
                                   input logic dma_req,
                                   input logic last_owner);
    if (host_req && dma_req) begin
      return (last_owner == OWNER_HOST) ? OWNER_DMA : OWNER_HOST;
    end else if (host_req) begin
      return OWNER_HOST;
    end else begin
      return OWNER_DMA;
    end
  endfunction

endpackage

// File: rtl/sd_cmd_arbiter_timer.sv
// sd_cmd_timer: wait-cycle counter for the command arbiter.
// The count is cleared while a command is being issued and advances once per
// enabled (WAIT) cycle. expire flags the enabled cycle that brings the count
// up to a nonzero limit, so a limit of N ends the wait after N cycles.
module sd_cmd_timer #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expire
);

  logic [TO_W-1:0] count_reg;
  logic [TO_W-1:0] count_inc;

  assign count_inc = count_reg + TO_W'(1);

  // Cycle counter: cleared before each wait, counts every waiting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_inc;
    end
  end

  assign expire = enable && (limit != '0) && (count_inc == limit);

endmodule

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: round-robin arbiter between the host register file and the
// DMA/BD engine for the single SD command master. One command is in flight at
// a time: IDLE samples requests, ISSUE pulses grant/new_cmd, WAIT holds until
// the command master reports completion.
// Optional feature macro: SD_CMD_TIMEOUT_EN adds a wait-cycle timeout that
// ends WAIT with err_o/timeout_o when cmd_done_i never arrives.
module sd_cmd_arbiter
  import sd_cmd_arbiter_pkg::*;
#(
  parameter int CMD_W = 16,
  parameter int ARG_W = 32,
  parameter int TO_W  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             host_req_i,
  input  logic [CMD_W-1:0] host_cmd_i,
  input  logic [ARG_W-1:0] host_arg_i,
  input  logic             dma_req_i,
  input  logic [CMD_W-1:0] dma_cmd_i,
  input  logic [ARG_W-1:0] dma_arg_i,
  output logic             host_gnt_o,
  output logic             dma_gnt_o,
  output logic [CMD_W-1:0] cmd_set_o,
  output logic [ARG_W-1:0] cmd_arg_o,
  output logic             new_cmd_o,
  input  logic             cmd_done_i,
  input  logic             cmd_err_i,
  input  logic [TO_W-1:0]  timeout_lim_i,
  output logic             busy_o,
  output logic             owner_o,
  output logic             host_done_o,
  output logic             dma_done_o,
  output logic             err_o,
  output logic             timeout_o
);

  arb_state_t       state_reg;
  arb_state_t       state_next;
  logic             last_owner_reg;
  logic             owner_reg;
  logic [CMD_W-1:0] cmd_reg;
  logic [ARG_W-1:0] arg_reg;
  logic             host_done_reg;
  logic             dma_done_reg;
  logic             err_reg;
  logic             any_req;
  logic             winner;
  logic             expire;
  logic             finish;

  assign any_req = host_req_i || dma_req_i;
  assign winner  = rr_pick(host_req_i, dma_req_i, last_owner_reg);
  // Completion beats a coinciding timeout, so done is checked first.
  assign finish  = (state_reg == ST_WAIT) && (cmd_done_i || expire);

`ifdef SD_CMD_TIMEOUT_EN
  logic timeout_reg;

  sd_cmd_timer #(
    .TO_W(TO_W)
  ) u_timer (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .clear  (state_reg == ST_ISSUE),
    .enable (state_reg == ST_WAIT),
    .limit  (timeout_lim_i),
    .expire (expire)
  );

  // Timeout flag pulses only when the wait ended without a completion.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= finish && !cmd_done_i;
    end
  end

  assign timeout_o = timeout_reg;
`else
  logic unused_lim;

  assign unused_lim = ^timeout_lim_i;
  assign expire     = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (any_req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (finish) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy_o     = 1'b0;
    new_cmd_o  = 1'b0;
    host_gnt_o = 1'b0;
    dma_gnt_o  = 1'b0;
    case (state_reg)
      ST_ISSUE: begin
        busy_o     = 1'b1;
        new_cmd_o  = 1'b1;
        host_gnt_o = (owner_reg == OWNER_HOST);
        dma_gnt_o  = (owner_reg == OWNER_DMA);
      end
      ST_WAIT:  busy_o = 1'b1;
      default:  busy_o = 1'b0;
    endcase
  end

  // Capture the winner's command when a request is accepted; held until the next grant.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cmd_reg        <= '0;
      arg_reg        <= '0;
      owner_reg      <= OWNER_HOST;
      last_owner_reg <= OWNER_DMA;
    end else if ((state_reg == ST_IDLE) && any_req) begin
      cmd_reg        <= (winner == OWNER_DMA) ? dma_cmd_i : host_cmd_i;
      arg_reg        <= (winner == OWNER_DMA) ? dma_arg_i : host_arg_i;
      owner_reg      <= winner;
      last_owner_reg <= winner;
    end
  end

  // One-cycle completion pulses routed to the current owner.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      host_done_reg <= 1'b0;
      dma_done_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      host_done_reg <= finish && (owner_reg == OWNER_HOST);
      dma_done_reg  <= finish && (owner_reg == OWNER_DMA);
      err_reg       <= finish && (cmd_done_i ? cmd_err_i : 1'b1);
    end
  end

  assign cmd_set_o   = cmd_reg;
  assign cmd_arg_o   = arg_reg;
  assign owner_o     = owner_reg;
  assign host_done_o = host_done_reg;
  assign dma_done_o  = dma_done_reg;
  assign err_o       = err_reg;

endmodule
